// File: rtl/systolic_pkg.sv
// Shared types for the systolic array drain side: accumulator width,
// output deskew FSM states and the default-sized result row type.
package systolic_pkg;

    function automatic int acc_width(input int datawidth);
        return datawidth * 4;
    endfunction

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_N_SIZE    = 32;
    localparam int DEF_ACC_W     = acc_width(DEF_DATAWIDTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } deskew_state_e;

    typedef logic [DEF_N_SIZE-1:0][DEF_ACC_W-1:0] acc_row_t;

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO for aligned result rows; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module row_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      free_cnt
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH[AW:0]);
    assign free_cnt = DEPTH[AW:0] - count;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rdata    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/systolic_output_deskew.sv
// Realigns skewed systolic array result rows, buffers them in a FIFO and
// tracks tile completion. Optional DESKEW_DROP_CNT_EN adds a dropped-row counter.
module systolic_output_deskew
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int N_SIZE     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ROW_CNT_W  = 10,
    localparam int ACC_W     = acc_width(DATAWIDTH),
    localparam int FREE_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROW_CNT_W-1:0]           tile_rows,
    input  logic                           in_valid,
    input  logic [N_SIZE-1:0][ACC_W-1:0]   matrix_C,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_SIZE-1:0][ACC_W-1:0]   out_row,
    output logic [FREE_W-1:0]              fifo_free,
    output logic                           busy,
    output logic                           tile_done,
    output logic                           overflow
`ifdef DESKEW_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    logic [N_SIZE-1:0][ACC_W-1:0] aligned_row;
    logic [N_SIZE-2:0]            valid_sr;
    logic                         aligned_valid;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;
    logic                         drop;

    deskew_state_e          state, state_next;
    logic [ROW_CNT_W-1:0]   row_cnt, row_cnt_next, row_cnt_inc;
    logic [ROW_CNT_W-1:0]   tile_rows_q, tile_rows_next;
    logic                   start_accept;

    // Column k lags column 0 by k cycles, so it gets N_SIZE-1-k stages.
    for (genvar k = 0; k < N_SIZE - 1; k++) begin : g_col
        localparam int D = N_SIZE - 1 - k;
        logic [ACC_W-1:0] stage [D];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < D; i++) stage[i] <= '0;
            end else begin
                stage[0] <= matrix_C[k];
                for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
            end
        end

        assign aligned_row[k] = stage[D-1];
    end
    assign aligned_row[N_SIZE-1] = matrix_C[N_SIZE-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_sr <= '0;
        else     valid_sr <= (valid_sr << 1) | (N_SIZE-1)'(in_valid);
    end
    assign aligned_valid = valid_sr[N_SIZE-2];

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = aligned_valid && fifo_full && !pop;

    row_fifo #(
        .WIDTH (N_SIZE * ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (aligned_valid),
        .pop      (pop),
        .wdata    (aligned_row),
        .rdata    (out_row),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (fifo_free)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            row_cnt     <= '0;
            tile_rows_q <= '0;
        end else begin
            state       <= state_next;
            row_cnt     <= row_cnt_next;
            tile_rows_q <= tile_rows_next;
        end
    end

    // Rows arriving while IDLE or DONE still enter the FIFO but are not counted.
    always_comb begin
        state_next     = state;
        row_cnt_next   = row_cnt;
        tile_rows_next = tile_rows_q;
        start_accept   = 1'b0;
        row_cnt_inc    = row_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    start_accept   = 1'b1;
                    tile_rows_next = (tile_rows == '0) ? ROW_CNT_W'(1) : tile_rows;
                    row_cnt_next   = '0;
                    state_next     = COLLECT;
                end
            end
            COLLECT: begin
                if (aligned_valid) begin
                    row_cnt_next = row_cnt_inc;
                    if (row_cnt_inc == tile_rows_q) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign tile_done = (state == DONE);

    // A drop coinciding with an accepted start belongs to the new tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overflow <= 1'b0;
        else if (start_accept) overflow <= drop;
        else if (drop)         overflow <= 1'b1;
    end

`ifdef DESKEW_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              drop_cnt <= '0;
        else if (start_accept)                drop_cnt <= {15'd0, drop};
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Randomized self-checking bench for systolic_output_deskew against a
// row-level model (issue history, FIFO queue, tile bookkeeping).
module tb_systolic_output_deskew;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int ACC_W = 32;
    localparam int RW    = N * ACC_W;
    localparam int MAXC  = 4096;

    typedef logic [N-1:0][ACC_W-1:0] row_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] tile_rows;
    logic       in_valid;
    row_t       matrix_C;
    logic       out_valid;
    logic       out_ready;
    row_t       out_row;
    logic [2:0] fifo_free;
    logic       busy;
    logic       tile_done;
    logic       overflow;
`ifdef DESKEW_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    systolic_output_deskew #(
        .DATAWIDTH  (8),
        .N_SIZE     (N),
        .FIFO_DEPTH (DEPTH),
        .ROW_CNT_W  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tile_rows (tile_rows),
        .in_valid  (in_valid),
        .matrix_C  (matrix_C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .fifo_free (fifo_free),
        .busy      (busy),
        .tile_done (tile_done),
        .overflow  (overflow)
`ifdef DESKEW_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   hist_v [MAXC];
    row_t hist_d [MAXC];
    row_t q [$];
    bit   m_busy, m_done, m_ovf;
    int   m_left, m_drops;

    task automatic checkOutput(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic row_t mkRow(input int base);
        row_t r;
        for (int k = 0; k < N; k++) r[k] = ACC_W'(base + k);
        return r;
    endfunction

    function automatic row_t rndRow();
        row_t r;
        for (int k = 0; k < N; k++) r[k] = $urandom;
        return r;
    endfunction

    // Row-level reference: a row issued at cycle t lands in the FIFO at the
    // end of cycle t+N-1 unless the FIFO is full and nothing pops.
    task automatic modelStep(input bit st, input int rows, input bit ready);
        int  ac;
        bit  arr, pop, drop;
        ac   = cyc - (N - 1);
        arr  = (ac >= 0) && hist_v[ac];
        pop  = (q.size() > 0) && ready;
        drop = arr && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (arr && !drop) q.push_back(hist_d[ac]);
        if (!m_busy) begin
            if (st) begin
                m_busy  = 1'b1;
                m_left  = (rows == 0) ? 1 : rows;
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (arr) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
    endtask

    task automatic compareAll();
        checkOutput("out_valid", RW'(out_valid), RW'(q.size() > 0));
        checkOutput("out_row", RW'(out_row), (q.size() > 0) ? RW'(q[0]) : RW'(0));
        checkOutput("fifo_free", RW'(fifo_free), RW'(DEPTH - q.size()));
        checkOutput("busy", RW'(busy), RW'(m_busy));
        checkOutput("tile_done", RW'(tile_done), RW'(m_done));
        checkOutput("overflow", RW'(overflow), RW'(m_ovf));
`ifdef DESKEW_DROP_CNT_EN
        checkOutput("drop_cnt", RW'(drop_cnt), RW'(m_drops));
`endif
    endtask

    // One clock cycle: drive at the falling edge, model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit st, input int rows, input bit vin, input row_t data, input bit ready);
        start     = st;
        tile_rows = 10'(rows);
        in_valid  = vin;
        out_ready = ready;
        hist_v[cyc] = vin;
        hist_d[cyc] = data;
        for (int k = 0; k < N; k++) begin
            if (cyc - k >= 0 && hist_v[cyc-k]) matrix_C[k] = hist_d[cyc-k][k];
            else                               matrix_C[k] = $urandom;
        end
        @(posedge clk);
        modelStep(st, rows, ready);
        @(negedge clk);
        compareAll();
        cyc++;
    endtask

    task automatic idleCycles(input int n, input bit ready);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, '0, ready);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_out_valid", RW'(out_valid), RW'(0));
        checkOutput("rst_fifo_free", RW'(fifo_free), RW'(DEPTH));
        checkOutput("rst_busy", RW'(busy), RW'(0));
        checkOutput("rst_out_row", RW'(out_row), RW'(0));
        q.delete();
        m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_drops = 0; m_left = 0;
        for (int i = 0; i < MAXC; i++) hist_v[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tile_rows = '0; in_valid = 1'b0;
        out_ready = 1'b0; matrix_C = '0;
        m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_drops = 0; m_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", RW'(out_valid), RW'(0));
        checkOutput("reset_fifo_free", RW'(fifo_free), RW'(DEPTH));
        checkOutput("reset_busy", RW'(busy), RW'(0));
        checkOutput("reset_tile_done", RW'(tile_done), RW'(0));
        checkOutput("reset_overflow", RW'(overflow), RW'(0));
        checkOutput("reset_out_row", RW'(out_row), RW'(0));
        rst = 1'b0;

        // Skew realignment: single-row tile, row lands four cycles after in_valid.
        $display("[TB] single row realignment");
        applyStimulus(1'b1, 1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, mkRow(10), 1'b1);
        idleCycles(3, 1'b1);
        checkOutput("t1_aligned_row", RW'(out_row), RW'(mkRow(10)));
        checkOutput("t1_out_valid", RW'(out_valid), RW'(1));
        idleCycles(6, 1'b1);

        $display("[TB] back-to-back tile");
        applyStimulus(1'b1, 3, 1'b0, '0, 1'b1);
        for (int r = 0; r < 3; r++) applyStimulus(1'b0, 0, 1'b1, mkRow(100 * r), 1'b1);
        idleCycles(8, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 4, 1'b0, '0, 1'b0);
        for (int r = 0; r < 4; r++) applyStimulus(1'b0, 0, 1'b1, mkRow(200 + 10 * r), 1'b0);
        idleCycles(4, 1'b0);
        idleCycles(8, 1'b1);

        $display("[TB] overflow");
        applyStimulus(1'b1, 5, 1'b0, '0, 1'b0);
        for (int r = 0; r < 5; r++) applyStimulus(1'b0, 0, 1'b1, mkRow(300 + 10 * r), 1'b0);
        idleCycles(5, 1'b0);
        checkOutput("t4_overflow", RW'(overflow), RW'(1));
        idleCycles(8, 1'b1);

        $display("[TB] full with simultaneous pop");
        applyStimulus(1'b1, 5, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 0, i < 5, mkRow(400 + 10 * i), (i == 7) || (i >= 10));
        idleCycles(4, 1'b1);

        $display("[TB] reset mid-tile");
        applyStimulus(1'b1, 4, 1'b0, '0, 1'b0);
        for (int r = 0; r < 4; r++) applyStimulus(1'b0, 0, 1'b1, mkRow(500 + 10 * r), 1'b0);
        idleCycles(1, 1'b0);
        doReset();
        idleCycles(10, 1'b1);

        $display("[TB] zero tile_rows");
        applyStimulus(1'b1, 0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, mkRow(600), 1'b1);
        idleCycles(6, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 6),
                          $urandom_range(0, 2) != 0, rndRow(), $urandom_range(0, 3) != 0);
        idleCycles(10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_output_deskew.md
Name: systolic_output_deskew

Overview:
- Drain-side companion of the weight-stationary systolic array.
- The array emits each result row skewed: column k appears k cycles after column 0. This block realigns each row into one word and buffers it in a FIFO.
- Rows are presented downstream with a valid/ready handshake. The block also counts rows per tile and flags rows lost to overflow.
- It sits between the array's bottom edge (matrix_C) and the output activation buffer.

Parameters:
- DATAWIDTH, 8: operand width; accumulator width ACC_W = DATAWIDTH*4.
- N_SIZE, 32: array columns, equal to the row width in elements.
- FIFO_DEPTH, 8: aligned-row FIFO entries; must be a power of 2 and at least 2.
- ROW_CNT_W, 10: width of the tile row counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new tile.
- tile_rows  in  ROW_CNT_W  rows expected in the tile; sampled on start; 0 is illegal and treated as 1.
- in_valid  in  1  column 0 of matrix_C holds the current row's result.
- matrix_C  in  ACC_W x N_SIZE  skewed array outputs.
- out_valid  out  1  an aligned row is available.
- out_ready  in  1  downstream accepts the row.
- out_row  out  ACC_W x N_SIZE  aligned row; element k = column k.
- fifo_free  out  $clog2(FIFO_DEPTH)+1  free FIFO entries.
- busy  out  1  high in COLLECT and DONE.
- tile_done  out  1  one-cycle pulse after the last row of the tile is written to the FIFO.
- overflow  out  1  sticky; set when a row is dropped; cleared by start.

Behaviour:
- Reset values:
  - All delay registers, FIFO pointers and counters are 0.
  - out_valid=0, busy=0, tile_done=0, overflow=0, fifo_free=FIFO_DEPTH, out_row=0.
- Deskew:
  - Column k passes through N_SIZE-1-k register stages; column N_SIZE-1 is unregistered.
  - in_valid passes through N_SIZE-1 stages, giving aligned_valid.
  - If in_valid is high at cycle t, the aligned row exists at cycle t+N_SIZE-1 and is written to the FIFO at the end of that cycle.
  - The delay lines never stall: the array cannot be backpressured.
- FIFO:
  - Registered pointers; out_row is driven from the head entry.
  - out_valid = not empty.
  - Pop when out_valid and out_ready are both high.
  - Minimum latency from in_valid to out_valid is N_SIZE cycles.
- Simultaneous push and pop when full: both happen; the row is not dropped.
- Push when full without a pop:
  - The row is discarded and overflow is set.
  - The row still counts toward tile_rows, so the tile terminates.
- Push while in IDLE: written to the FIFO but not counted.
- FSM states:
  - IDLE: on start, latch tile_rows, clear row_cnt and overflow, go to COLLECT.
  - COLLECT: row_cnt increments on each aligned_valid. When the incremented count equals tile_rows, go to DONE.
  - DONE: assert tile_done for one cycle, then go to IDLE.
- start outside IDLE is ignored, and no state changes.
- Reset mid-tile: FIFO contents are lost, the FSM goes to IDLE, and rows in the delay lines are discarded.

Optional Feature:
- Macro: DESKEW_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt, 16 bits.
  - drop_cnt increments per dropped row, saturates at 0xFFFF, and clears on start and on rst.
- When not defined: the port and the counter are absent. overflow is unaffected either way.

Decomposition:
- Shared package systolic_pkg holds:
  - the ACC_W derivation function;
  - typedef deskew_state_e {IDLE, COLLECT, DONE};
  - typedef acc_row_t, a packed array of N_SIZE x ACC_W.
- One natural sub-module, row_fifo: a synchronous FIFO parameterized on width and depth, with full, empty and free-count outputs.
- The deskew shift registers stay inline in a generate loop.

Test Plan (N_SIZE=4, FIFO_DEPTH=4):
1. Skew realignment:
   - Stimulus: start, tile_rows=1; in_valid at cycle 0; feed column k the value 10+k at cycle k; out_ready=1.
   - Required: out_valid rises at cycle 4 with out_row={10,11,12,13}; tile_done pulses; busy falls.
2. Back-to-back tile:
   - Stimulus: tile_rows=3; in_valid on cycles 0-2 with row r, column k = 100r+k.
   - Required: three consecutive out_valid beats with aligned rows; exactly one tile_done pulse.
3. Backpressure:
   - Stimulus: out_ready=0; tile_rows=4 rows.
   - Required: fifo_free steps 4→0; no overflow; rows then drain in order when out_ready=1.
4. Overflow:
   - Stimulus: out_ready=0; tile_rows=5.
   - Required: 5th row dropped; overflow=1; tile_done still pulses; drop_cnt=1 when DESKEW_DROP_CNT_EN is defined.
5. Full with simultaneous pop:
   - Stimulus: FIFO full; pop on the same cycle as a push.
   - Required: no drop; fifo_free stays 0; row order preserved.
6. Reset mid-tile:
   - Stimulus: assert rst during COLLECT with 2 rows buffered.
   - Required: out_valid=0, fifo_free=4 and busy=0 immediately; no stale row appears after release.
